// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller, datapath and bench.
package pipeline_ctrl_pkg;

   // Controller FSM encoding; values are fixed so other blocks can decode them.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWait  = 2'd1,
      StFlush = 2'd2
   } state_e;

   // Stage indices in pipe order; fetch is bit 0.
   localparam int unsigned STAGE_IF  = 0;
   localparam int unsigned STAGE_ID  = 1;
   localparam int unsigned STAGE_EX  = 2;
   localparam int unsigned STAGE_MEM = 3;
   localparam int unsigned STAGE_WB  = 4;

   // Width of the flush-length down-counter (FLUSH_CYCLES is 1..15).
   localparam int unsigned FLUSH_CNT_W = 4;

endpackage

// File: rtl/pipeline_ctrl_stall_vec.sv
// Suffix-OR of stall requests: a stalling stage freezes itself and every
// earlier stage, while later stages keep draining.
module pipeline_ctrl_stall_vec #(
   parameter int unsigned STAGES = 5
) (
   input  logic [STAGES-1:0] stall_req_i,
   output logic [STAGES-1:0] stall_vec_o
);

   logic acc;

   // Walk from the youngest stage down, accumulating any later request.
   always_comb begin
      stall_vec_o = '0;
      acc         = 1'b0;
      for (int i = int'(STAGES) - 1; i >= 0; i--) begin
         acc            = acc | stall_req_i[i];
         stall_vec_o[i] = acc;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: per-stage stall vector, sequenced flush with PC
// redirect, and a saturating stalled-cycle counter.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned STAGES       = 5,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [STAGES-1:0]     stall_req_in,
   input  logic [STAGES-1:0]     busy_in,
   input  logic                  flush_req_in,
   input  logic [ADDR_WIDTH-1:0] flush_pc_in,
   output logic [STAGES-1:0]     stall_out,
   output logic                  flush_out,
   output logic                  redirect_valid_out,
   output logic [ADDR_WIDTH-1:0] redirect_pc_out,
   output logic [CNT_WIDTH-1:0]  stall_cycles_out
);

   localparam logic [FLUSH_CNT_W-1:0] FlushInit = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [FLUSH_CNT_W-1:0] FlushOne  = FLUSH_CNT_W'(1);
   localparam logic [CNT_WIDTH-1:0]   CntOne    = CNT_WIDTH'(1);

   state_e                  state_q, state_d;
   logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic                    flush_q, flush_d;
   logic                    redirect_valid_q, redirect_valid_d;
   logic [ADDR_WIDTH-1:0]   redirect_pc_q, redirect_pc_d;
   logic [CNT_WIDTH-1:0]    stall_cnt_q, stall_cnt_d;
   logic [STAGES-1:0]       suffix_stall;

   pipeline_ctrl_stall_vec #(
      .STAGES(STAGES)
   ) u_stall_vec (
      .stall_req_i(stall_req_in),
      .stall_vec_o(suffix_stall)
   );

   // Stall vector: requests in IDLE, full freeze in WAIT, none in FLUSH or reset.
   always_comb begin
      stall_out = '0;
      if (rst) begin
         unique case (state_q)
            StIdle:  stall_out = suffix_stall;
            StWait:  stall_out = '1;
            default: stall_out = '0;
         endcase
      end
   end

   // Next-state, flush sequencing and stall counter.
   always_comb begin
      state_d          = state_q;
      flush_cnt_d      = flush_cnt_q;
      pc_d             = pc_q;
      flush_d          = 1'b0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      stall_cnt_d      = stall_cnt_q;

      if ((stall_out != '0) && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CntOne;
      end

      case (state_q)
         StIdle: begin
            if (flush_req_in) begin
               pc_d = flush_pc_in;
               if (busy_in == '0) begin
                  state_d          = StFlush;
                  flush_cnt_d      = FlushInit;
                  flush_d          = 1'b1;
                  redirect_valid_d = 1'b1;
                  redirect_pc_d    = flush_pc_in;
               end else begin
                  state_d = StWait;
               end
            end
         end
         // Later flush requests are dropped: the oldest one already latched wins.
         StWait: begin
            if (busy_in == '0) begin
               state_d          = StFlush;
               flush_cnt_d      = FlushInit;
               flush_d          = 1'b1;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = pc_q;
            end
         end
         StFlush: begin
            if (flush_cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               flush_cnt_d = flush_cnt_q - FlushOne;
               flush_d     = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q          <= StIdle;
         flush_cnt_q      <= '0;
         pc_q             <= '0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         stall_cnt_q      <= '0;
      end else begin
         state_q          <= state_d;
         flush_cnt_q      <= flush_cnt_d;
         pc_q             <= pc_d;
         flush_q          <= flush_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         stall_cnt_q      <= stall_cnt_d;
      end
   end

   assign flush_out          = flush_q;
   assign redirect_valid_out = redirect_valid_q;
   assign redirect_pc_out    = redirect_pc_q;
   assign stall_cycles_out   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: three instances (default, 3-cycle flush,
// 4-bit counter) share one stimulus stream; each task checks the relevant one.
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  stall_req = '0;
   logic [4:0]  busy = '0;
   logic        flush_req = 1'b0;
   logic [31:0] flush_pc = '0;

   logic [4:0]  a_stall, b_stall, c_stall;
   logic        a_flush, b_flush, c_flush;
   logic        a_rv, b_rv, c_rv;
   logic [31:0] a_pc, b_pc, c_pc;
   logic [31:0] a_cnt, b_cnt;
   logic [3:0]  c_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipeline_ctrl u_a (
      .clk(clk), .rst(rst), .stall_req_in(stall_req), .busy_in(busy),
      .flush_req_in(flush_req), .flush_pc_in(flush_pc), .stall_out(a_stall),
      .flush_out(a_flush), .redirect_valid_out(a_rv), .redirect_pc_out(a_pc),
      .stall_cycles_out(a_cnt)
   );

   pipeline_ctrl #(.FLUSH_CYCLES(3)) u_b (
      .clk(clk), .rst(rst), .stall_req_in(stall_req), .busy_in(busy),
      .flush_req_in(flush_req), .flush_pc_in(flush_pc), .stall_out(b_stall),
      .flush_out(b_flush), .redirect_valid_out(b_rv), .redirect_pc_out(b_pc),
      .stall_cycles_out(b_cnt)
   );

   pipeline_ctrl #(.CNT_WIDTH(4)) u_c (
      .clk(clk), .rst(rst), .stall_req_in(stall_req), .busy_in(busy),
      .flush_req_in(flush_req), .flush_pc_in(flush_pc), .stall_out(c_stall),
      .flush_out(c_flush), .redirect_valid_out(c_rv), .redirect_pc_out(c_pc),
      .stall_cycles_out(c_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; stall_req = '0; busy = '0; flush_req = 1'b0; flush_pc = '0;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; stall_req = 5'b11111; flush_req = 1'b1; flush_pc = 32'hBFC00380; busy = '0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (a_stall !== 5'b0) begin errors++; $display("FAIL reset_stall: got %b expected 00000", a_stall); end
         step();
         checks++; if (a_flush !== 1'b0 || a_rv !== 1'b0) begin errors++; $display("FAIL reset_flush: got flush=%b rv=%b expected 0 0", a_flush, a_rv); end
         checks++; if (a_pc !== 32'h0 || a_cnt !== 32'h0) begin errors++; $display("FAIL reset_regs: got pc=%h cnt=%0d expected 0 0", a_pc, a_cnt); end
      end
      rst = 1'b1; stall_req = '0; flush_req = 1'b0; flush_pc = '0;
      step();
      checks++; if (u_a.state_q !== StIdle) begin errors++; $display("FAIL reset_state: got %0d expected %0d", u_a.state_q, StIdle); end
      checks++; if (a_stall !== 5'b0 || a_flush !== 1'b0) begin errors++; $display("FAIL reset_release: got stall=%b flush=%b expected 00000 0", a_stall, a_flush); end
   endtask

   task automatic test_stall_suffix();
      do_reset();
      stall_req = 5'b00100;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (a_stall !== 5'b00111) begin errors++; $display("FAIL stall_suffix: got %b expected 00111", a_stall); end
         step();
      end
      checks++; if (a_cnt !== 32'd4) begin errors++; $display("FAIL stall_count: got %0d expected 4", a_cnt); end
      stall_req = 5'b10010;
      #1;
      checks++; if (a_stall !== 5'b11111) begin errors++; $display("FAIL stall_suffix_wb: got %b expected 11111", a_stall); end
      stall_req = 5'b00001;
      #1;
      checks++; if (a_stall !== 5'b00001) begin errors++; $display("FAIL stall_suffix_if: got %b expected 00001", a_stall); end
      stall_req = '0;
      #1;
      checks++; if (a_stall !== 5'b0) begin errors++; $display("FAIL stall_clear: got %b expected 00000", a_stall); end
      step();
   endtask

   task automatic test_immediate_flush();
      do_reset();
      flush_req = 1'b1; flush_pc = 32'hBFC00380; stall_req = 5'b00010;
      #1;
      checks++; if (a_stall !== 5'b00011) begin errors++; $display("FAIL flush_same_cycle_stall: got %b expected 00011", a_stall); end
      checks++; if (a_flush !== 1'b0) begin errors++; $display("FAIL flush_early: got %b expected 0", a_flush); end
      step();
      flush_req = 1'b0; flush_pc = '0; stall_req = '0;
      #1;
      checks++; if (a_flush !== 1'b1 || a_rv !== 1'b1) begin errors++; $display("FAIL flush_pulse: got flush=%b rv=%b expected 1 1", a_flush, a_rv); end
      checks++; if (a_pc !== 32'hBFC00380) begin errors++; $display("FAIL flush_pc: got %h expected bfc00380", a_pc); end
      checks++; if (a_stall !== 5'b0) begin errors++; $display("FAIL flush_stall: got %b expected 00000", a_stall); end
      step();
      checks++; if (a_flush !== 1'b0 || a_rv !== 1'b0) begin errors++; $display("FAIL flush_end: got flush=%b rv=%b expected 0 0", a_flush, a_rv); end
   endtask

   task automatic test_deferred_flush();
      do_reset();
      busy = 5'b01000; flush_req = 1'b1; flush_pc = 32'h80000180;
      step();
      flush_pc = 32'h00001234;
      #1;
      checks++; if (a_stall !== 5'b11111) begin errors++; $display("FAIL wait_stall1: got %b expected 11111", a_stall); end
      step();
      flush_req = 1'b0; flush_pc = '0;
      #1;
      checks++; if (a_stall !== 5'b11111 || a_flush !== 1'b0) begin errors++; $display("FAIL wait_stall2: got stall=%b flush=%b expected 11111 0", a_stall, a_flush); end
      step();
      busy = '0;
      #1;
      checks++; if (a_stall !== 5'b11111 || a_flush !== 1'b0) begin errors++; $display("FAIL wait_last: got stall=%b flush=%b expected 11111 0", a_stall, a_flush); end
      checks++; if (a_pc === 32'h00001234) begin errors++; $display("FAIL wait_pc: got %h expected not 00001234", a_pc); end
      step();
      checks++; if (a_flush !== 1'b1 || a_rv !== 1'b1) begin errors++; $display("FAIL deferred_pulse: got flush=%b rv=%b expected 1 1", a_flush, a_rv); end
      checks++; if (a_pc !== 32'h80000180) begin errors++; $display("FAIL deferred_pc: got %h expected 80000180", a_pc); end
      checks++; if (a_stall !== 5'b0) begin errors++; $display("FAIL deferred_stall: got %b expected 00000", a_stall); end
      step();
      checks++; if (a_flush !== 1'b0 || a_rv !== 1'b0) begin errors++; $display("FAIL deferred_end: got flush=%b rv=%b expected 0 0", a_flush, a_rv); end
      checks++; if (a_pc !== 32'h80000180) begin errors++; $display("FAIL deferred_pc_hold: got %h expected 80000180", a_pc); end
      checks++; if (a_cnt !== 32'd3) begin errors++; $display("FAIL wait_count: got %0d expected 3", a_cnt); end
   endtask

   task automatic test_long_flush();
      logic [2:0] exp_flush;
      logic [2:0] exp_rv;
      exp_flush = 3'b111;
      exp_rv    = 3'b001;
      do_reset();
      flush_req = 1'b1; flush_pc = 32'h00400000;
      step();
      flush_pc = 32'hDEAD0000;
      for (int k = 0; k < 3; k++) begin
         checks++; if (b_flush !== exp_flush[k] || b_rv !== exp_rv[k]) begin errors++; $display("FAIL long_flush_c%0d: got flush=%b rv=%b expected %b %b", k, b_flush, b_rv, exp_flush[k], exp_rv[k]); end
         checks++; if (b_pc !== 32'h00400000) begin errors++; $display("FAIL long_flush_pc_c%0d: got %h expected 00400000", k, b_pc); end
         step();
      end
      flush_req = 1'b0; flush_pc = '0;
      checks++; if (b_flush !== 1'b0 || b_rv !== 1'b0) begin errors++; $display("FAIL long_flush_end: got flush=%b rv=%b expected 0 0", b_flush, b_rv); end
      step();
      checks++; if (b_flush !== 1'b0 || b_rv !== 1'b0 || b_pc !== 32'h00400000) begin errors++; $display("FAIL long_flush_ignored: got flush=%b rv=%b pc=%h expected 0 0 00400000", b_flush, b_rv, b_pc); end
   endtask

   task automatic test_saturation_and_abort();
      logic [3:0] exp_cnt;
      do_reset();
      stall_req = 5'b10000;
      for (int k = 1; k <= 20; k++) begin
         step();
         exp_cnt = (k > 15) ? 4'hF : 4'(k);
         checks++; if (c_cnt !== exp_cnt) begin errors++; $display("FAIL sat_count_c%0d: got %h expected %h", k, c_cnt, exp_cnt); end
      end
      stall_req = '0; busy = 5'b00001; flush_req = 1'b1; flush_pc = 32'hCAFE0000;
      step();
      flush_req = 1'b0; flush_pc = '0;
      #1;
      checks++; if (c_stall !== 5'b11111) begin errors++; $display("FAIL abort_in_wait: got %b expected 11111", c_stall); end
      step();
      rst = 1'b0; busy = '0;
      #1;
      checks++; if (c_stall !== 5'b0) begin errors++; $display("FAIL abort_stall_forced: got %b expected 00000", c_stall); end
      step();
      rst = 1'b1;
      checks++; if (c_cnt !== 4'h0 || c_flush !== 1'b0) begin errors++; $display("FAIL abort_reset: got cnt=%h flush=%b expected 0 0", c_cnt, c_flush); end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (c_rv !== 1'b0 || c_flush !== 1'b0 || c_pc !== 32'h0 || c_stall !== 5'b0) begin errors++; $display("FAIL abort_no_redirect_c%0d: got rv=%b flush=%b pc=%h stall=%b expected 0 0 0 00000", k, c_rv, c_flush, c_pc, c_stall); end
      end
   endtask

   initial begin
      test_reset();
      test_stall_suffix();
      test_immediate_flush();
      test_deferred_flush();
      test_long_flush();
      test_saturation_and_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central pipeline controller that drives the stall and flush inputs consumed by every inter-stage pipeline register.
- Collects per-stage stall requests and per-stage "uninterruptible bus op" flags.
- Collects flush/redirect requests from the exception/branch unit.
- Produces the per-stage stall vector, a sequenced flush pulse, and the PC redirect for fetch.
- Sits beside the datapath in the core top; the control-side counterpart of the stage registers.

Parameters:
STAGES, 5, number of pipeline stages; bit 0 = fetch (oldest index = lowest position in pipe order)
ADDR_WIDTH, 32, PC width
FLUSH_CYCLES, 1, cycles flush_out is held high (1..15)
CNT_WIDTH, 32, stall performance counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
stall_req_in  in  STAGES  stage i requests a stall (cache miss, multicycle div, ...)
busy_in  in  STAGES  stage i has an in-flight bus transaction that must not be abandoned
flush_req_in  in  1  flush request (exception, eret, mispredict)
flush_pc_in  in  ADDR_WIDTH  redirect target, valid with flush_req_in
stall_out  out  STAGES  per-stage stall to pipeline registers
flush_out  out  1  flush to all pipeline registers
redirect_valid_out  out  1  one-cycle pulse: fetch loads redirect_pc_out
redirect_pc_out  out  ADDR_WIDTH  redirect target
stall_cycles_out  out  CNT_WIDTH  saturating count of stalled cycles

Behaviour:
Reset: when rst is low at a clock edge:
- state goes to IDLE.
- flush_out, redirect_valid_out, redirect_pc_out, stall_cycles_out, internal flush counter and latched PC all go to 0.
- stall_out is forced 0 while rst is low.

Stall vector (combinational, IDLE only):
- stall_out[i] = OR of stall_req_in[j] for all j >= i.
- A stalling stage freezes itself and all earlier stages; later stages drain. Their registers insert bubbles via the stall_current && !stall_next rule.

FSM states: IDLE, WAIT, FLUSH.
- IDLE, flush_req_in=1, busy_in==0: latch flush_pc_in; go to FLUSH. flush_out=1 and redirect_valid_out=1 from the next cycle (latency 1).
- IDLE, flush_req_in=1, busy_in!=0: latch flush_pc_in; go to WAIT.
- WAIT: stall_out = all ones, so nothing advances while a bus op completes. Flush requests are ignored; the first (oldest) request wins. When busy_in==0, go to FLUSH next cycle.
- FLUSH: flush_out=1 for exactly FLUSH_CYCLES cycles. redirect_valid_out=1 only in the first FLUSH cycle. redirect_pc_out holds the latched PC for the whole FLUSH period. stall_out = 0. flush_req_in is ignored. After the last cycle, return to IDLE with flush_out=0.

Other rules:
- flush_out, redirect_valid_out and redirect_pc_out are registered outputs (glitch-free).
- A flush request and a stall request in the same IDLE cycle: stall_out follows the stall requests for that cycle; the flush proceeds as above.
- stall_cycles_out increments by 1 on every cycle where stall_out != 0 (includes WAIT). It saturates at all-ones and does not wrap.
- FLUSH_CYCLES=1 gives a single-cycle flush; IDLE→FLUSH→IDLE takes 2 edges.
- Reset in WAIT or FLUSH aborts immediately; the latched PC is discarded and no redirect is issued.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, WAIT=2'd1, FLUSH=2'd2) and the STAGES index constants (STAGE_IF..STAGE_WB). These are reused by the datapath and the bench.
- Natural sub-module: pipeline_ctrl_stall_vec, the combinational suffix-OR of stall requests. The FSM and counter stay in pipeline_ctrl.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with stall_req_in=5'b11111 and flush_req_in=1 -> all outputs 0, counter 0; release -> state IDLE.
2. Stall suffix: stall_req_in=5'b00100 for 4 cycles -> stall_out=5'b00111 each cycle; stall_cycles_out ends at 4; stall_req_in=0 -> stall_out=0.
3. Immediate flush: IDLE, busy_in=0, flush_req_in=1 with pc=0xBFC00380 for 1 cycle -> next cycle flush_out=1, redirect_valid_out=1, redirect_pc_out=0xBFC00380; the following cycle both are 0.
4. Deferred flush: busy_in=5'b01000 for 3 cycles, flush at cycle 0 with pc=0x80000180, second flush at cycle 1 with pc=0x1234 -> stall_out=5'b11111 in WAIT; flush pulse carries 0x80000180 one cycle after busy_in clears; 0x1234 never appears.
5. FLUSH_CYCLES=3: single flush request -> flush_out high exactly 3 cycles; redirect_valid_out high only in the first; flush_req_in during FLUSH is ignored.
6. Counter saturation (CNT_WIDTH=4): continuous stall for 20 cycles -> stall_cycles_out stops at 4'hF, no wrap; reset mid-WAIT -> no redirect_valid_out afterwards.
